// File: rtl/srl_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : srl_check_pkg
//  Description : Shared types and constants for the SRL chain checker and
//                the reusable LFSR stimulus generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package srl_check_pkg;

    // Checker sequencing: settle after reset, fill the chain, then compare
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2
    } state_t;

    // 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting right.
    // Polynomial taps 16,14,13,11 land on state bits 0,2,3,5.
    localparam int unsigned              c_LFSR_W            = 16;
    localparam logic [c_LFSR_W-1:0]      c_LFSR_TAP_MASK     = 16'h002D;
    localparam logic [c_LFSR_W-1:0]      c_LFSR_SEED_DEFAULT = 16'hACE1;

    // Clock-enable gap pattern, consumed LSB first: 1,1,0,1
    localparam logic [3:0]               c_CE_GAP_PATTERN    = 4'b1011;

    // One LFSR step: feedback is the parity of the tapped bits
    function automatic logic [c_LFSR_W-1:0] lfsr_step(input logic [c_LFSR_W-1:0] s);
        return {^(s & c_LFSR_TAP_MASK), s[c_LFSR_W-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/srl_chain_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : srl_chain_checker_if
//  Description : Bundle between the checker and the SRL chain under test,
//                plus the pass/fail status going to the board LEDs.
//                master = checker side, slave = chain/board side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface srl_chain_checker_if #(
    parameter int ERR_W = 8
);
    logic             srl_d;
    logic             srl_ce;
    logic             srl_q;
    logic [ERR_W-1:0] error;
    logic             armed;

    modport master (
        output srl_d,
        output srl_ce,
        output error,
        output armed,
        input  srl_q
    );

    modport slave (
        input  srl_d,
        input  srl_ce,
        input  error,
        input  armed,
        output srl_q
    );
endinterface
`default_nettype wire

// File: rtl/srl_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : srl_lfsr
//  Description : 16-bit Fibonacci LFSR with step enable and async reset to a
//                parameterised seed. Shared by the SRL/shift test designs.
//  Revision    : 1.0 - initial release
// ============================================================================
module srl_lfsr
    import srl_check_pkg::*;
#(
    parameter logic [c_LFSR_W-1:0] SEED = c_LFSR_SEED_DEFAULT
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_en,
    output logic [c_LFSR_W-1:0]      o_state
);

    logic [c_LFSR_W-1:0] r_state;

    // Advance one step per enabled cycle; hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/srl_chain_checker.sv
`default_nettype none
// ============================================================================
//  Module      : srl_chain_checker
//  Description : Drives a pseudo-random bit stream and shift enable into an
//                SRL chain, mirrors the chain with a golden shift register
//                and counts (saturating) every cycle where the returned tap
//                disagrees with the golden tap.
//                Optional build macro SRL_CHECK_CE_GAP_EN: shift enable
//                follows the repeating pattern 1,1,0,1 instead of being
//                held high, to exercise chain hold behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module srl_chain_checker
    import srl_check_pkg::*;
#(
    parameter int                    SRL_LENGTH = 32,
    parameter logic [c_LFSR_W-1:0]   LFSR_SEED  = c_LFSR_SEED_DEFAULT,
    parameter int                    ERR_W      = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    srl_chain_checker_if.master    bus
);

    localparam int                 c_CNT_W      = $clog2(SRL_LENGTH + 1);
    localparam logic [c_CNT_W-1:0] c_PRIME_LAST = c_CNT_W'(SRL_LENGTH - 1);
    localparam logic [ERR_W-1:0]   c_ERR_MAX    = '1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_srl_ce;
    logic                    w_ce_next;
    logic                    r_armed;
    logic                    w_armed_next;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CNT_W-1:0]      w_cnt_next;
    logic                    r_srl_d;
    logic [SRL_LENGTH-1:0]   r_model;
    logic [SRL_LENGTH-1:0]   w_model_next;
    logic                    w_exp_tap;
    logic [ERR_W-1:0]        r_error;
    logic [c_LFSR_W-1:0]     w_lfsr;
    logic                    w_ce_gate;
    logic                    w_unused;

    // ------------------------------------------------------------------
    // Shift-enable source
    // ------------------------------------------------------------------
`ifdef SRL_CHECK_CE_GAP_EN
    logic [1:0] r_phase;

    // Free-running phase: it sits at 0 through reset and IDLE, so the
    // first enable issued on IDLE exit is pattern entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= 2'd0;
        end else begin
            r_phase <= r_phase + 2'd1;
        end
    end

    assign w_ce_gate = c_CE_GAP_PATTERN[r_phase];
`else
    assign w_ce_gate = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Stimulus generator
    // ------------------------------------------------------------------
    srl_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (r_srl_ce),
        .o_state (w_lfsr)
    );

    // Only the two low LFSR bits feed the serial output
    assign w_unused = ^w_lfsr[c_LFSR_W-1:2];

    // srl_d tracks LFSR bit 0 as it stands after this edge: on a shifting
    // edge that is the incoming bit 1, otherwise the current bit 0. Every
    // bit the chain samples is therefore fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_srl_d <= 1'b0;
        end else begin
            r_srl_d <= r_srl_ce ? w_lfsr[1] : w_lfsr[0];
        end
    end

    // ------------------------------------------------------------------
    // Golden model of the chain: shifts on the same edges as the chain
    // ------------------------------------------------------------------
    generate
        if (SRL_LENGTH == 1) begin : g_model_single
            assign w_model_next = r_srl_d;
        end else begin : g_model_shift
            assign w_model_next = {r_model[SRL_LENGTH-2:0], r_srl_d};
        end
    endgenerate

    // Golden shift register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_model <= '0;
        end else if (r_srl_ce) begin
            r_model <= w_model_next;
        end
    end

    assign w_exp_tap = r_model[SRL_LENGTH-1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    // State and registered control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_srl_ce <= 1'b0;
            r_armed  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_srl_ce <= w_ce_next;
            r_armed  <= w_armed_next;
            r_cnt    <= w_cnt_next;
        end
    end

    // Next state: IDLE lasts one cycle, PRIME counts SRL_LENGTH enabled
    // shifts, CHECK is terminal until reset.
    always_comb begin
        w_state_next = r_state;
        w_ce_next    = r_srl_ce;
        w_armed_next = r_armed;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                w_state_next = PRIME;
                w_ce_next    = w_ce_gate;
            end
            PRIME: begin
                w_ce_next = w_ce_gate;
                if (r_srl_ce) begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == c_PRIME_LAST) begin
                        w_state_next = CHECK;
                        w_armed_next = 1'b1;
                    end
                end
            end
            CHECK: begin
                w_ce_next = w_ce_gate;
            end
            default: begin
                w_state_next = IDLE;
                w_ce_next    = 1'b0;
                w_armed_next = 1'b0;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Compare and count
    // ------------------------------------------------------------------
    // Compare every CHECK cycle, stalled or not. The equality is written so
    // an unknown tap falls into the mismatch branch in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= '0;
        end else if (r_state == CHECK) begin
            if (bus.srl_q == w_exp_tap) begin
                r_error <= r_error;
            end else if (r_error != c_ERR_MAX) begin
                r_error <= r_error + 1'b1;
            end
        end
    end

    assign bus.srl_d  = r_srl_d;
    assign bus.srl_ce = r_srl_ce;
    assign bus.armed  = r_armed;
    assign bus.error  = r_error;

endmodule
`default_nettype wire
